// File: rtl/calltrace_pkg.sv
// Shared definitions for the calltrace dump block.
// Holds the calltrace control-word bit positions, the status-word field
// positions, the dump FSM state type and the trap IR encodings that the
// calltrace block also decodes.
// Optional feature macro: CALLTRACE_DUMP_BLOCK_EN adds the BLOCK/UNBLK states.
package calltrace_pkg;

  // calltrace control-word bits (written to calltrace addr 1)
  localparam int CT_CLEAR    = 1;
  localparam int CT_FREEZE   = 2;
  localparam int CT_UNFREEZE = 3;
  localparam int CT_BLOCK    = 4;
  localparam int CT_UNBLOCK  = 5;

  // calltrace status-word fields (read from calltrace addr 1)
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_MSB = 15;
  localparam int ST_OVFL    = 2;
  localparam int ST_PID_LSB = 24;
  localparam int ST_PID_MSB = 28;

  // trap IR encodings shared with calltrace (opcode / funct12)
  localparam logic [6:0]  IR_OPC_TRAP = 7'b1110011;
  localparam logic [11:0] IR_F12_TRAP = 12'h000;
  localparam logic [11:0] IR_F12_TRET = 12'h302;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FREEZE = 3'd1,
    S_STAT   = 3'd2,
    S_READ   = 3'd3,
    S_UNFRZ  = 3'd4,
    S_DONE   = 3'd5
`ifdef CALLTRACE_DUMP_BLOCK_EN
    , S_BLOCK = 3'd6
    , S_UNBLK = 3'd7
`endif
  } dump_state_e;

  // one-hot control word for a single calltrace control bit
  function automatic logic [23:0] ctl_word(input int b);
    return 24'(1) << b;
  endfunction

endpackage

// File: rtl/calltrace_dump_if.sv
// Bus bundle of the calltrace dump block.
// Carries both the CPU-side slave port (stb/we/addr/data_in/data_out/ack)
// and the initiator port toward calltrace (ct_*).
// Modports: master = the dump block's view (drives ct_* requests and the
// slave responses); slave = the environment's view (CPU decoder + calltrace).
interface calltrace_dump_if;
  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        ct_stb;
  logic        ct_we;
  logic        ct_addr;
  logic [23:0] ct_dout;
  logic [31:0] ct_din;
  logic        ct_ack;

  modport master (
    input  stb, we, addr, data_in, ct_din, ct_ack,
    output data_out, ack, ct_stb, ct_we, ct_addr, ct_dout
  );
  modport slave (
    output stb, we, addr, data_in, ct_din, ct_ack,
    input  data_out, ack, ct_stb, ct_we, ct_addr, ct_dout
  );
endinterface

// File: rtl/calltrace_dump_buf.sv
// Capture buffer for one calltrace snapshot.
// Ports: i_clr empties the buffer; i_wr/i_wdata append one entry (dropped
// when full); i_rd advances the read index while it points at a captured
// entry; o_rdata = {valid, 7'b0, entry}, all zero past the last entry;
// o_wr_idx = entries captured, o_rd_idx = current read index.
module calltrace_dump_buf #(
  parameter int NUM_SLOTS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_wr,
  input  logic [23:0] i_wdata,
  input  logic        i_rd,
  output logic [31:0] o_rdata,
  output logic [7:0]  o_wr_idx,
  output logic [7:0]  o_rd_idx
);
  localparam int AW = $clog2(NUM_SLOTS);

  logic [23:0] r_mem [NUM_SLOTS];
  logic [7:0]  r_wr_idx, r_rd_idx;
  logic        w_valid, w_full;

  assign w_valid = (r_rd_idx < r_wr_idx);
  assign w_full  = (r_wr_idx == 8'(NUM_SLOTS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
    end else if (i_clr) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
    end else begin
      if (i_wr && !w_full) r_wr_idx <= r_wr_idx + 8'd1;
      // no wrap: the index parks on the first empty slot
      if (i_rd && w_valid) r_rd_idx <= r_rd_idx + 8'd1;
    end
  end

  // contents need no reset: reads are gated by the indices
  always_ff @(posedge clk) begin
    if (i_wr && !w_full) r_mem[r_wr_idx[AW-1:0]] <= i_wdata;
  end

  assign o_rdata  = w_valid ? {1'b1, 7'b0, r_mem[r_rd_idx[AW-1:0]]} : 32'b0;
  assign o_wr_idx = r_wr_idx;
  assign o_rd_idx = r_rd_idx;
endmodule

// File: rtl/calltrace_dump.sv
// Hardware calltrace dumper.
// On an armed trig edge or a software start it freezes the calltrace stack,
// reads its status and all entries into a local buffer, then unfreezes.
// Software reads the snapshot later through the two-register slave port.
// Ports: clk, rst_n (async, active low), trig (level, edge-detected),
// busy (dump in progress), bus (calltrace_dump_if.master: slave port
// stb/we/addr/data_in/data_out/ack, initiator port ct_*).
// Optional feature macro: CALLTRACE_DUMP_BLOCK_EN brackets the dump with
// calltrace BLOCK/UNBLOCK writes so the trap handler cannot disturb the trace.
module calltrace_dump
  import calltrace_pkg::*;
#(
  parameter int NUM_SLOTS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  output logic              busy,
  calltrace_dump_if.master  bus
);
  dump_state_e r_state, w_nxt;
  logic        r_trig_q, r_armed, r_done, r_trunc, r_ovfl;
  logic [4:0]  r_pid;
  logic [7:0]  r_cnt;

  logic        w_ctl_wr, w_clr, w_trig_p, w_start, w_acc, w_dat_rd, w_buf_wr, w_last;
  logic [7:0]  w_wr_idx, w_rd_idx, w_nidx, w_din_cnt;
  logic [31:0] w_rdata, w_status;
  logic        w_unused;

  assign w_ctl_wr  = bus.stb & bus.we & bus.addr;
  assign w_clr     = w_ctl_wr & bus.data_in[1] & (r_state == S_IDLE);
  assign w_trig_p  = trig & ~r_trig_q;
  // a clear in the same write as start frees the done lock first
  assign w_start   = (r_state == S_IDLE) & ~(r_done & ~w_clr) &
                     ((r_armed & w_trig_p) | (w_ctl_wr & bus.data_in[0]));
  assign w_acc     = bus.ct_stb & bus.ct_ack;
  assign w_dat_rd  = bus.stb & ~bus.we & ~bus.addr;
  assign w_buf_wr  = (r_state == S_READ) & w_acc;
  assign w_din_cnt = bus.ct_din[ST_CNT_MSB:ST_CNT_LSB];
  assign w_nidx    = w_wr_idx + 8'd1;
  assign w_last    = (w_nidx == r_cnt) | (w_nidx == 8'(NUM_SLOTS));
  assign w_unused  = ^{bus.data_in[31:4], bus.ct_din[31:29]};

  calltrace_dump_buf #(.NUM_SLOTS(NUM_SLOTS)) u_buf (
    .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_wr(w_buf_wr),
    .i_wdata(bus.ct_din[23:0]), .i_rd(w_dat_rd),
    .o_rdata(w_rdata), .o_wr_idx(w_wr_idx), .o_rd_idx(w_rd_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
`ifdef CALLTRACE_DUMP_BLOCK_EN
      S_IDLE:   if (w_start) w_nxt = S_BLOCK;
      S_BLOCK:  if (w_acc)   w_nxt = S_FREEZE;
      S_UNFRZ:  if (w_acc)   w_nxt = S_UNBLK;
      S_UNBLK:  if (w_acc)   w_nxt = S_DONE;
`else
      S_IDLE:   if (w_start) w_nxt = S_FREEZE;
      S_UNFRZ:  if (w_acc)   w_nxt = S_DONE;
`endif
      S_FREEZE: if (w_acc)   w_nxt = S_STAT;
      S_STAT:   if (w_acc)   w_nxt = (w_din_cnt == 8'd0) ? S_UNFRZ : S_READ;
      S_READ:   if (w_acc && w_last) w_nxt = S_UNFRZ;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ct_stb  = 1'b0;
    bus.ct_we   = 1'b0;
    bus.ct_addr = 1'b0;
    bus.ct_dout = '0;
    busy        = (r_state != S_IDLE);
    case (r_state)
`ifdef CALLTRACE_DUMP_BLOCK_EN
      S_BLOCK:  begin bus.ct_stb = 1'b1; bus.ct_we = 1'b1; bus.ct_addr = 1'b1; bus.ct_dout = ctl_word(CT_BLOCK);   end
      S_UNBLK:  begin bus.ct_stb = 1'b1; bus.ct_we = 1'b1; bus.ct_addr = 1'b1; bus.ct_dout = ctl_word(CT_UNBLOCK); end
`endif
      S_FREEZE: begin bus.ct_stb = 1'b1; bus.ct_we = 1'b1; bus.ct_addr = 1'b1; bus.ct_dout = ctl_word(CT_FREEZE);   end
      S_STAT:   begin bus.ct_stb = 1'b1; bus.ct_addr = 1'b1; end
      S_READ:   begin bus.ct_stb = 1'b1; end
      S_UNFRZ:  begin bus.ct_stb = 1'b1; bus.ct_we = 1'b1; bus.ct_addr = 1'b1; bus.ct_dout = ctl_word(CT_UNFREEZE); end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_q <= 1'b0;
      r_armed  <= 1'b0;
      r_done   <= 1'b0;
      r_trunc  <= 1'b0;
      r_ovfl   <= 1'b0;
      r_pid    <= '0;
      r_cnt    <= '0;
    end else begin
      r_trig_q <= trig;
      // disarm wins over arm in the same write
      if (w_ctl_wr && bus.data_in[3])      r_armed <= 1'b0;
      else if (w_ctl_wr && bus.data_in[2]) r_armed <= 1'b1;
      if (w_clr) begin
        r_done  <= 1'b0;
        r_trunc <= 1'b0;
        r_ovfl  <= 1'b0;
        r_pid   <= '0;
        r_cnt   <= '0;
      end
      if (r_state == S_STAT && w_acc) begin
        r_pid   <= bus.ct_din[ST_PID_MSB:ST_PID_LSB];
        r_cnt   <= w_din_cnt;
        r_ovfl  <= bus.ct_din[ST_OVFL];
        r_trunc <= (32'(w_din_cnt) > NUM_SLOTS);
      end
      if (r_state == S_DONE) r_done <= 1'b1;
    end
  end

  assign w_status = {busy, r_done, r_trunc, r_ovfl, r_armed, 6'b0, r_pid, w_wr_idx, w_rd_idx};

  assign bus.ack      = bus.stb;
  assign bus.data_out = bus.stb ? (bus.addr ? w_status : w_rdata) : 32'b0;
endmodule

// File: tb/tb_calltrace_dump.sv
module tb_calltrace_dump;
  localparam int NSLOTS = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic trig;
  logic busy;

  calltrace_dump_if bus();

  calltrace_dump #(.NUM_SLOTS(NSLOTS)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- calltrace stack model ----------------
  logic [23:0] m_mem [64];
  logic [7:0]  m_cnt;
  logic [4:0]  m_pid;
  logic        m_ovfl;
  int          m_wait;
  int          m_wc  = 0;
  int          m_ptr = 0;
  logic [25:0] log_q[$];
  int          busy_cyc = 0;
  int          stb_cyc  = 0;

  assign bus.ct_ack = bus.ct_stb && (m_wc == m_wait);

  always_comb begin
    if (bus.ct_addr) bus.ct_din = {3'b0, m_pid, 8'h00, m_cnt, 5'b0, m_ovfl, 2'b0};
    else             bus.ct_din = {8'h00, m_mem[m_ptr[5:0]]};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_wc <= 0;
    else if (bus.ct_stb) begin
      if (bus.ct_ack) begin
        m_wc <= 0;
        log_q.push_back({bus.ct_we, bus.ct_addr, bus.ct_dout});
        if (bus.ct_we && bus.ct_dout == 24'h000004) m_ptr <= 0;
        else if (!bus.ct_we && !bus.ct_addr)        m_ptr <= m_ptr + 1;
      end else m_wc <= m_wc + 1;
    end
  end

  always @(posedge clk) begin
    if (busy)       busy_cyc <= busy_cyc + 1;
    if (bus.ct_stb) stb_cyc  <= stb_cyc + 1;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sw_write(input logic a, input logic [31:0] d);
    @(negedge clk);
    bus.stb = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    bus.stb = 1'b0; bus.we = 1'b0; bus.data_in = '0;
  endtask

  task automatic sw_read(input logic a, output logic [31:0] d);
    @(negedge clk);
    bus.stb = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1 d = bus.data_out;
    @(negedge clk);
    bus.stb = 1'b0;
  endtask

  task automatic setup(input int cnt, input logic [4:0] pid, input logic ov, input int w, input bit rnd);
    m_cnt = 8'(cnt); m_pid = pid; m_ovfl = ov; m_wait = w;
    for (int i = 0; i < 64; i++) m_mem[i] = rnd ? 24'($urandom) : 24'((i + 1) * 256);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (!busy && t < 20) begin @(negedge clk); t++; end
    t = 0;
    while (busy && t < 5000) begin @(negedge clk); t++; end
    chk({tag, "_timeout"}, {31'b0, busy}, 32'b0);
  endtask

  task automatic no_activity(input string tag);
    int bl = log_q.size();
    int bb = busy_cyc;
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    repeat (8) @(negedge clk);
    chk({tag, "_accesses"}, 32'(log_q.size() - bl), 32'd0);
    chk({tag, "_busy"},     32'(busy_cyc - bb),      32'd0);
  endtask

  // kick a dump, then compare bus sequence, timing, status and buffer
  // contents against what the stack model says must have been captured
  task automatic dump_and_check(input string tag, input bit use_trig,
                                input logic [31:0] sw_data, input logic armed_exp);
    logic [25:0] e[$];
    logic [25:0] got;
    logic [31:0] d;
    int bl = log_q.size();
    int bb = busy_cyc;
    int bs = stb_cyc;
    int n_rd = (int'(m_cnt) > NSLOTS) ? NSLOTS : int'(m_cnt);

    @(negedge clk);
    if (use_trig) trig = 1'b1;
    if (sw_data != 0) begin bus.stb = 1'b1; bus.we = 1'b1; bus.addr = 1'b1; bus.data_in = sw_data; end
    @(negedge clk);
    trig = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.data_in = '0;
    wait_idle(tag);

`ifdef CALLTRACE_DUMP_BLOCK_EN
    e.push_back({2'b11, 24'h000010});
`endif
    e.push_back({2'b11, 24'h000004});
    e.push_back({2'b01, 24'h000000});
    for (int i = 0; i < n_rd; i++) e.push_back({2'b00, 24'h000000});
    e.push_back({2'b11, 24'h000008});
`ifdef CALLTRACE_DUMP_BLOCK_EN
    e.push_back({2'b11, 24'h000020});
`endif

    chk({tag, "_nacc"}, 32'(log_q.size() - bl), 32'(e.size()));
    for (int i = 0; i < e.size() && bl + i < log_q.size(); i++) begin
      got = log_q[bl + i];
      if (!got[25]) got[23:0] = '0;  // write data is don't-care on reads
      chk($sformatf("%s_acc%0d", tag, i), {6'b0, got}, {6'b0, e[i]});
    end
    chk({tag, "_busy_span"}, 32'(busy_cyc - bb), 32'(e.size() * (m_wait + 1) + 1));
    chk({tag, "_stb_span"},  32'(stb_cyc - bs),  32'(e.size() * (m_wait + 1)));

    sw_read(1'b1, d);
    chk({tag, "_status"}, d, {1'b0, 1'b1, 1'(int'(m_cnt) > NSLOTS), m_ovfl, armed_exp,
                              6'b0, m_pid, 8'(n_rd), 8'h00});
    for (int i = 0; i < n_rd; i++) begin
      sw_read(1'b0, d);
      chk($sformatf("%s_data%0d", tag, i), d, {1'b1, 7'b0, m_mem[i]});
    end
    sw_read(1'b0, d);
    chk({tag, "_past_end"}, d, 32'h0);
    sw_read(1'b1, d);
    chk({tag, "_rd_idx"}, {24'b0, d[7:0]}, 32'(n_rd));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    int t;
    int bl;
    rst_n = 1'b0; trig = 1'b0;
    bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 1'b0; bus.data_in = '0;
    setup(0, 5'd0, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, bus.ct_stb, bus.ct_we, bus.ct_addr, 4'b0, bus.ct_dout},  32'h0);
    chk("reset_rdata", bus.data_out, 32'h0);
    rst_n = 1'b1;
    sw_read(1'b1, d); chk("reset_status", d, 32'h0);
    sw_read(1'b0, d); chk("reset_data", d, 32'h0);

    // armed trig dump of a 3-entry stack
    sw_write(1'b1, 32'h4);
    sw_read(1'b1, d); chk("armed_status", d, 32'h0800_0000);
    setup(3, 5'd5, 1'b0, 0, 1'b0);
    dump_and_check("trig3", 1'b1, 32'h0, 1'b1);

    // done lock, then clear, then disarmed (arm+disarm: disarm wins)
    no_activity("done_lock");
    sw_write(1'b1, 32'h2);
    sw_read(1'b1, d); chk("clear_status", d, 32'h0800_0000);
    sw_write(1'b1, 32'hC);
    sw_read(1'b1, d); chk("armdisarm_status", d, 32'h0);
    no_activity("disarmed");

    // software start with an empty stack
    setup(0, 5'($urandom), 1'b0, 0, 1'b1);
    dump_and_check("empty", 1'b0, 32'h1, 1'b0);

    // clear+start in one write, oversized stack truncates
    setup(40, 5'($urandom), 1'b1, 0, 1'b1);
    dump_and_check("trunc", 1'b0, 32'h3, 1'b0);

    // wait states, trig and software start together: one dump only
    sw_write(1'b1, 32'h2);
    sw_write(1'b1, 32'h4);
    setup(3, 5'd5, 1'b0, 2, 1'b0);
    dump_and_check("wait2", 1'b1, 32'h1, 1'b1);

    // random depth, one wait state
    sw_write(1'b1, 32'h2);
    setup(int'($urandom_range(32, 1)), 5'($urandom), 1'($urandom), 1, 1'b1);
    dump_and_check("rand", 1'b1, 32'h0, 1'b1);

    // reset in the middle of READ
    sw_write(1'b1, 32'h2);
    setup(10, 5'd9, 1'b0, 2, 1'b1);
    bl = log_q.size();
    sw_write(1'b1, 32'h1);
    t = 0;
    while (log_q.size() - bl < 3 && t < 200) begin @(negedge clk); t++; end
    chk("reach_read", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {busy, bus.ct_stb, bus.ct_we, bus.ct_addr, 4'b0, bus.ct_dout}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sw_read(1'b1, d); chk("midrst_status", d, 32'h0);

    // fresh dump after the reset
    setup(int'($urandom_range(32, 1)), 5'($urandom), 1'($urandom), 0, 1'b1);
    dump_and_check("post_rst", 1'b0, 32'h1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/calltrace_dump.md
Name: calltrace_dump

Overview:
- Hardware reader for the per-process calltrace stacks.
- On a trap/error trigger, or on a software command, it acts as an IO-bus initiator toward the calltrace block and snapshots the current process' trace.
  - Sequence: freeze the stack, read its status, read all entries, unfreeze.
  - Entries go into a local buffer.
- Software later retrieves the buffered trace through the block's own two-register IO port, even after the live stack has changed.

Parameters:
- num_slots, 32, buffer depth in entries; must equal the calltrace stack depth (power of 2, max 128).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trig  in  1  error/trap event; level, edge-detected internally
- stb  in  1  slave strobe from CPU IO decoder
- we  in  1  slave write enable
- addr  in  1  slave register select: 0 = data, 1 = ctrl/status
- data_in  in  32  slave write data
- data_out  out  32  slave read data; 0 when not addressed
- ack  out  1  slave ack; equals stb
- ct_stb  out  1  initiator strobe to calltrace
- ct_we  out  1  initiator write enable
- ct_addr  out  1  initiator register select
- ct_dout  out  24  initiator write data (calltrace control word)
- ct_din  in  32  calltrace read data
- ct_ack  in  1  calltrace ack
- busy  out  1  dump in progress; the system mux routes calltrace IO to this block and stalls CPU calltrace access while high

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; buffer empty; armed = 0; all flags 0.
- Trigger pulse: trig_p = trig & ~trig_q, with trig_q registered.
- Dump start condition (IDLE only): (armed & trig_p) | software start. Starts are ignored when not IDLE, or when done = 1; done is cleared only by a software clear, so the first trace is kept.
- Every initiator access:
  - ct_stb is held until ct_ack is sampled high.
  - The FSM advances in the cycle after ack.
  - Read data is captured on the ack cycle.
- FSM states and actions:
  - IDLE: wait for a start condition.
  - FREEZE: write addr 1 with ct_dout = 24'h000004.
  - STAT: read addr 1.
    - Capture pid = ct_din[28:24], cnt = ct_din[15:8], ovfl = ct_din[2].
    - If cnt = 0, go to UNFRZ.
  - READ: read addr 0 repeatedly.
    - Each ack writes ct_din[23:0] into the buffer at the write index, then increments the index.
    - Leave when cnt reads are done, or when the buffer holds num_slots entries.
    - If cnt > num_slots: stop at num_slots entries and set trunc = 1.
  - UNFRZ: write addr 1 with ct_dout = 24'h000008.
  - DONE: set done = 1, go to IDLE.
- busy = 1 in every state except IDLE.
- Initiator bus: each state drives ct_stb = 1 for its access. In all other states ct_stb = 0 and ct_we = 0.
- Buffer: num_slots x 24 register array.
  - Write index is 8 bits.
  - Read index advances on each slave data read.
  - Reading past the last captured entry returns 0 with bit 31 = 0 and does not advance the index (no wrap).
- Slave data read (addr 0): {valid, 7'b0, entry[23:0]}. Index order 0..n-1 matches the calltrace frozen read order, top first.
- Slave status read (addr 1), bit fields:
  - [31] busy, [30] done, [29] trunc, [28] ovfl, [27] armed
  - [20:16] pid
  - [15:8] entries captured
  - [7:0] read index
- Slave ctrl write (addr 1), data_in bits:
  - [0] start
  - [1] clear: empties the buffer, zeroes indices and flags. Ignored while busy.
  - [2] arm
  - [3] disarm
- Slave data write (addr 0): no effect.
- Simultaneous events:
  - arm and disarm in the same write: disarm wins.
  - trig_p and software start in the same cycle: a single dump starts.
  - clear and start in the same write: clear first, then start.
- Reset mid-dump: asynchronous return to IDLE. The calltrace stack may remain frozen; software unfreezes it.

Optional Feature:
- Macro: CALLTRACE_DUMP_BLOCK_EN.
- Defined:
  - A BLOCK state before FREEZE writes 24'h000010 (block hw push/pop).
  - An UNBLK state after UNFRZ writes 24'h000020.
  - The trace is then not disturbed by the trap handler's own calls during the dump.
- Undefined: both states are absent; FREEZE directly follows IDLE and DONE directly follows UNFRZ.

Decomposition:
- Package calltrace_pkg holds:
  - calltrace control bit constants (CLEAR = 1, FREEZE = 2, UNFREEZE = 3, BLOCK = 4, UNBLOCK = 5);
  - status field positions (count [15:8], ovfl [2], pid [28:24]);
  - the FSM state enum;
  - the trap IR encodings shared with calltrace.
- One sub-module: calltrace_dump_buf, the register-array buffer with write/read indices and valid logic.

Test Plan:
- Arm, then stack model with pid 5 holding 3 entries 0x000100/0x000200/0x000300 and trig pulse -> bus sequence: ctrl write 0x000004, status read, 3 data reads, ctrl write 0x000008. busy high for exactly that span. Status reads done = 1, pid = 5, entries = 3. Data reads return 0x80000100, 0x80000200, 0x80000300, then 0x00000000.
- Software start with cnt = 0 -> only FREEZE, STAT and UNFRZ accesses. entries = 0; first data read = 0.
- num_slots = 32 and model cnt = 40 with ovfl = 1 -> 32 data reads; status shows trunc = 1, ovfl = 1, entries = 32.
- Second trig while done = 1, and trig while disarmed -> no ct_stb activity. After a clear write, a trig with armed = 1 starts a new dump.
- Model inserting 2 wait cycles before each ct_ack -> ct_stb held for 3 cycles per access; captured data identical to the zero-wait run.
- rst_n low during READ -> outputs 0 immediately and FSM in IDLE. With CALLTRACE_DUMP_BLOCK_EN defined, a normal dump is bracketed by writes 0x000010 and 0x000020.
